// File: rtl/gals_ttfs_event_encoder.sv
// GALS ANN->SNN boundary encoder. It converts each 4-phase activation vector to time-to-first-spike
// events and streams them out as AER {addr,time} through a small first-word fall-through FIFO.
module gals_ttfs_event_encoder #(
    parameter int PIXEL_VEC_LEN = 8,
    parameter int NUM_PIXELS    = 20,
    parameter int DATA_W        = 8,
    parameter int TIME_W        = 8,
    parameter int SHIFT_W       = 3,
    parameter int FIFO_DEPTH    = 4,
    parameter int VEC_LEN       = NUM_PIXELS * PIXEL_VEC_LEN,
    parameter int ADDR_W        = $clog2(VEC_LEN),
    parameter int ECNT_W        = $clog2(VEC_LEN + 1)
) (
    input  logic                            local_clk,
    input  logic                            rst_n,
    input  logic [DATA_W-1:0]               cfg_k_min,
    input  logic [SHIFT_W-1:0]              cfg_shift,
    input  logic [TIME_W-1:0]               cfg_t_max,
    input  logic                            cfg_emit_silent,
    input  logic                            i_abort,
    input  logic                            i_data_req,
    output logic                            o_data_ack,
    input  logic [PIXEL_VEC_LEN*DATA_W-1:0] i_data_bus,
    output logic                            o_aer_req,
    input  logic                            i_aer_ack,
    output logic [ADDR_W-1:0]               o_aer_addr,
    output logic [TIME_W-1:0]               o_aer_time,
    output logic [ECNT_W-1:0]               o_event_cnt,
    output logic                            o_frame_done,
    output logic                            o_busy
);

    localparam int CALC_W = ((DATA_W > TIME_W) ? DATA_W : TIME_W) + 2;
    localparam int PIX_W  = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam int CH_W   = (PIXEL_VEC_LEN > 1) ? $clog2(PIXEL_VEC_LEN) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W  = ADDR_W + TIME_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_SCAN,
        S_DRAIN,
        S_DONE,
        S_WAIT_REL
    } state_t;

    state_t state_reg, state_next;

    // Frame-latched configuration and the captured activation vector
    logic [DATA_W-1:0]               k_min_reg;
    logic [SHIFT_W-1:0]              shift_reg;
    logic [TIME_W-1:0]               t_max_reg;
    logic                            emit_silent_reg;
    logic [PIXEL_VEC_LEN*DATA_W-1:0] data_reg;

    logic [PIX_W-1:0]  pixel_idx_reg;
    logic [CH_W-1:0]   ch_reg;
    logic              ack_reg;
    logic [ECNT_W-1:0] event_cnt_reg;

    logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic              fifo_empty, fifo_full;
    logic              accept, cfg_load, push, pop, ch_adv, ch_last, pix_last, emit, ack_next;
    logic [TIME_W-1:0] t_all [PIXEL_VEC_LEN];
    logic [TIME_W-1:0] t_cur;
    logic [ADDR_W-1:0] cur_addr;
    logic signed [CALC_W-1:0] t_max_w;
    logic [ENT_W-1:0]  head;

    assign t_max_w = $signed({{(CALC_W-TIME_W){t_max_reg[TIME_W-1]}}, t_max_reg});

    // Every channel gets its own TTFS datapath; SCAN only selects the current one
    for (genvar gi = 0; gi < PIXEL_VEC_LEN; gi++) begin : g_ch
        logic [DATA_W-1:0]        x;
        logic signed [CALC_W-1:0] sub_w;
        logic signed [CALC_W-1:0] sh_w;
        logic [TIME_W-1:0]        clamp_t;

        assign x     = data_reg[gi*DATA_W +: DATA_W];
        assign sub_w = $signed({{(CALC_W-DATA_W){x[DATA_W-1]}}, x})
                     - $signed({{(CALC_W-DATA_W){k_min_reg[DATA_W-1]}}, k_min_reg});
        assign sh_w  = sub_w >>> shift_reg;
        // Clamped value lies in [0,T_MAX], so it always fits the time width
        assign clamp_t = (sh_w < 0)       ? '0 :
                         (sh_w > t_max_w) ? t_max_reg :
                                            sh_w[TIME_W-1:0];
        assign t_all[gi] = t_max_reg - clamp_t;
    end

    assign t_cur      = t_all[ch_reg];
    assign cur_addr   = ADDR_W'(pixel_idx_reg) * ADDR_W'(PIXEL_VEC_LEN) + ADDR_W'(ch_reg);
    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
    assign ch_last    = (ch_reg == CH_W'(PIXEL_VEC_LEN - 1));
    assign pix_last   = (pixel_idx_reg == PIX_W'(NUM_PIXELS - 1));
    assign emit       = ($signed(t_cur) < $signed(t_max_reg)) || emit_silent_reg;
    assign head       = fifo_mem[rd_ptr_reg];

    // State register
    always_ff @(posedge local_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; abort overrides everything
    always_comb begin
        state_next = state_reg;
        if (i_abort) begin
            state_next = S_WAIT_REL;
        end else begin
            case (state_reg)
                S_IDLE:     if (i_data_req) state_next = S_ACK;
                S_ACK:      if (!i_data_req) state_next = S_SCAN;
                S_SCAN:     if (ch_adv && ch_last) state_next = pix_last ? S_DRAIN : S_IDLE;
                S_DRAIN:    if (fifo_empty) state_next = S_DONE;
                S_DONE:     state_next = S_IDLE;
                S_WAIT_REL: if (!i_data_req) state_next = S_IDLE;
                default:    state_next = S_IDLE;
            endcase
        end
    end

    // Control outputs of the FSM
    always_comb begin
        accept   = 1'b0;
        cfg_load = 1'b0;
        push     = 1'b0;
        ch_adv   = 1'b0;
        pop      = 1'b0;
        ack_next = 1'b0;
        if (!i_abort) begin
            accept   = (state_reg == S_IDLE) && i_data_req;
            cfg_load = accept && (pixel_idx_reg == '0);
            if (state_reg == S_SCAN) begin
                push   = emit && !fifo_full;
                ch_adv = !emit || !fifo_full;
            end
            pop      = !fifo_empty && i_aer_ack;
            ack_next = (state_next == S_ACK);
        end
    end

    // Datapath, counters and FIFO bookkeeping
    always_ff @(posedge local_clk or negedge rst_n) begin
        if (!rst_n) begin
            k_min_reg       <= '0;
            shift_reg       <= '0;
            t_max_reg       <= '0;
            emit_silent_reg <= 1'b0;
            data_reg        <= '0;
            pixel_idx_reg   <= '0;
            ch_reg          <= '0;
            ack_reg         <= 1'b0;
            event_cnt_reg   <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
        end else if (i_abort) begin
            pixel_idx_reg <= '0;
            ch_reg        <= '0;
            ack_reg       <= 1'b0;
            event_cnt_reg <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
        end else begin
            ack_reg <= ack_next;
            if (accept) begin
                data_reg <= i_data_bus;
            end
            if (cfg_load) begin
                k_min_reg       <= cfg_k_min;
                shift_reg       <= cfg_shift;
                t_max_reg       <= cfg_t_max;
                emit_silent_reg <= cfg_emit_silent;
            end
            if (ch_adv) begin
                ch_reg <= ch_last ? '0 : ch_reg + CH_W'(1);
                if (ch_last && !pix_last) begin
                    pixel_idx_reg <= pixel_idx_reg + PIX_W'(1);
                end
            end
            if (state_reg == S_DONE) begin
                pixel_idx_reg <= '0;
            end
            if (cfg_load) begin
                event_cnt_reg <= '0;
            end else if (pop) begin
                event_cnt_reg <= event_cnt_reg + ECNT_W'(1);
            end
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge local_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {cur_addr, t_cur};
        end
    end

    assign o_data_ack   = ack_reg;
    assign o_aer_req    = !fifo_empty;
    assign o_aer_addr   = fifo_empty ? '0 : head[ENT_W-1 -: ADDR_W];
    assign o_aer_time   = fifo_empty ? '0 : head[TIME_W-1:0];
    assign o_event_cnt  = event_cnt_reg;
    assign o_frame_done = (state_reg == S_DONE);
    assign o_busy       = (state_reg != S_IDLE) || !fifo_empty;

endmodule
